// File: rtl/conv_defines_pkg.sv
// Shared definitions for the convolution datapath: tap width, default
// kernel depth and default lane count for the multi-channel shifter.
package conv_defines_pkg;

    localparam int DATA_WIDTH    = 8;
    localparam int SHIFTER_DEPTH = 9;
    localparam int MC_NUM_CH     = 4;

    typedef logic [DATA_WIDTH-1:0] tap_t;

endpackage

// File: rtl/shifter_lane.sv
// One channel of the kernel-tap shifter: DEPTH taps that either shift a
// new tap in at the tail or rotate left, with entry 0 exposed as the head.
module shifter_lane #(
    parameter int DATA_WIDTH = conv_defines_pkg::DATA_WIDTH,
    parameter int DEPTH      = conv_defines_pkg::SHIFTER_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  do_load,
    input  logic                  do_rot,
    input  logic [DATA_WIDTH-1:0] lane_in,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] r_taps [DEPTH];

    // Tap storage: flush, shift-in at the tail, or left-rotate; load has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_taps[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) r_taps[i] <= '0;
        end else if (do_load) begin
            for (int i = 0; i < DEPTH-1; i++) r_taps[i] <= r_taps[i+1];
            r_taps[DEPTH-1] <= lane_in;
        end else if (do_rot) begin
            for (int i = 0; i < DEPTH-1; i++) r_taps[i] <= r_taps[i+1];
            r_taps[DEPTH-1] <= r_taps[0];
        end
    end

    assign head = r_taps[0];

endmodule

// File: rtl/shifter_conv_mc.sv
// Multi-channel kernel-tap shifter. NUM_CH lanes load and rotate in
// lockstep; this top owns all control (fire decode, fill count, head
// position, pass-complete pulse) and the lanes only hold data.
//
// Load handshake: a tap vector is taken on a rising edge where
// load_valid and load_ready are both high and clear is low. load_ready is
// combinational (!full | cfg_slide) and never depends on load_valid; the
// producer must hold load_valid/load_data stable until that edge.
module shifter_conv_mc #(
    parameter int DATA_WIDTH = conv_defines_pkg::DATA_WIDTH,
    parameter int DEPTH      = conv_defines_pkg::SHIFTER_DEPTH,
    parameter int NUM_CH     = conv_defines_pkg::MC_NUM_CH,
    localparam int CW        = $clog2(DEPTH+1),
    localparam int IW        = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         cfg_slide,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] load_data,
    input  logic                         rot_en,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
    output logic [CW-1:0]                fill_count,
    output logic                         full,
    output logic                         empty,
    output logic [IW-1:0]                head_idx,
    output logic                         pass_done
);

    logic [CW-1:0] r_fill;
    logic [IW-1:0] r_head;
    logic          r_pass;

    logic w_full;
    logic w_fire;
    logic w_rot;
    logic w_wrap;

    assign w_full     = (r_fill == CW'(DEPTH));
    assign load_ready = !w_full | cfg_slide;

    // Clear suppresses both operations; a load fire shadows a same-cycle rotate,
    // and rotation is only meaningful once every tap is valid.
    always_comb begin
        w_fire = 1'b0;
        w_rot  = 1'b0;
        w_wrap = 1'b0;
        if (!clear) begin
            w_fire = load_valid & load_ready;
            w_rot  = rot_en & w_full & !w_fire;
        end
        w_wrap = w_rot & (r_head == IW'(DEPTH-1));
    end

    // Fill counter: saturates at DEPTH so slide loads keep it pinned at full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill <= '0;
        end else if (clear) begin
            r_fill <= '0;
        end else if (w_fire && !w_full) begin
            r_fill <= r_fill + 1'b1;
        end
    end

    // Head position: rotations since last load/clear, wrapping at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
        end else if (clear || w_fire) begin
            r_head <= '0;
        end else if (w_rot) begin
            r_head <= w_wrap ? '0 : r_head + 1'b1;
        end
    end

    // Pass-complete pulse: one cycle after the rotate that restores load order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else if (clear) begin
            r_pass <= 1'b0;
        end else begin
            r_pass <= w_wrap;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_lane
            shifter_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .DEPTH      (DEPTH)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .clear   (clear),
                .do_load (w_fire),
                .do_rot  (w_rot),
                .lane_in (load_data[k*DATA_WIDTH +: DATA_WIDTH]),
                .head    (out_data[k*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    assign fill_count = r_fill;
    assign full       = w_full;
    assign empty      = (r_fill == '0);
    assign head_idx   = r_head;
    assign pass_done  = r_pass;

endmodule

// File: tb/tb_shifter_conv_mc.sv
// Directed bench for shifter_conv_mc: DEPTH=9 main instance plus DEPTH=4
// and DEPTH=25 instances for the lockstep depth sweep.
module tb_shifter_conv_mc;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main DUT (DEPTH=9)
  logic        clear, cfg_slide, load_valid, rot_en;
  logic [31:0] load_data;
  logic        load_ready, full, empty, pass_done;
  logic [31:0] out_data;
  logic [3:0]  fill_count;
  logic [3:0]  head_idx;

  // sweep DUTs (DEPTH=4, DEPTH=25)
  logic        lv4, re4, lr4, full4, empty4, pd4;
  logic [31:0] ld4, od4;
  logic [2:0]  fc4;
  logic [1:0]  hi4;
  logic        lv25, re25, lr25, full25, empty25, pd25;
  logic [31:0] ld25, od25;
  logic [4:0]  fc25;
  logic [4:0]  hi25;

  shifter_conv_mc dut (
    .clk(clk), .rst(rst), .clear(clear), .cfg_slide(cfg_slide),
    .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
    .rot_en(rot_en), .out_data(out_data), .fill_count(fill_count),
    .full(full), .empty(empty), .head_idx(head_idx), .pass_done(pass_done)
  );

  shifter_conv_mc #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .clear(1'b0), .cfg_slide(1'b0),
    .load_valid(lv4), .load_ready(lr4), .load_data(ld4),
    .rot_en(re4), .out_data(od4), .fill_count(fc4),
    .full(full4), .empty(empty4), .head_idx(hi4), .pass_done(pd4)
  );

  shifter_conv_mc #(.DEPTH(25)) dut25 (
    .clk(clk), .rst(rst), .clear(1'b0), .cfg_slide(1'b0),
    .load_valid(lv25), .load_ready(lr25), .load_data(ld25),
    .rot_en(re25), .out_data(od25), .fill_count(fc25),
    .full(full25), .empty(empty25), .head_idx(hi25), .pass_done(pd25)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // lane k carries 16*k + n
  function automatic logic [31:0] lanes(input int n);
    return {8'(48 + n), 8'(32 + n), 8'(16 + n), 8'(n)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load9(input int n, input logic with_rot);
    load_valid = 1'b1;
    load_data  = lanes(n);
    rot_en     = with_rot;
    step();
    load_valid = 1'b0;
    rot_en     = 1'b0;
  endtask

  task automatic rot9();
    rot_en = 1'b1;
    step();
    rot_en = 1'b0;
  endtask

  task automatic sweep(input int sel, input int depth);
    logic [31:0] got;
    for (int n = 1; n <= depth; n++) begin
      if (sel == 0) begin lv4 = 1'b1; ld4 = lanes(n); end
      else          begin lv25 = 1'b1; ld25 = lanes(n); end
      step();
      lv4 = 1'b0; lv25 = 1'b0;
    end
    got = (sel == 0) ? {31'd0, full4} : {31'd0, full25};
    check_eq($sformatf("sweep%0d_full", depth), got, 32'd1);
    got = (sel == 0) ? od4 : od25;
    check_eq($sformatf("sweep%0d_head_loaded", depth), got, lanes(1));
    for (int r = 1; r <= depth; r++) exp_q.push_back(lanes((r % depth) + 1));
    for (int r = 1; r <= depth; r++) begin
      if (sel == 0) re4 = 1'b1; else re25 = 1'b1;
      step();
      re4 = 1'b0; re25 = 1'b0;
      got = (sel == 0) ? od4 : od25;
      check_eq($sformatf("sweep%0d_rot%0d", depth, r), got, exp_q.pop_front());
    end
    got = (sel == 0) ? {31'd0, pd4} : {31'd0, pd25};
    check_eq($sformatf("sweep%0d_pass_done", depth), got, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; clear = 1'b0; cfg_slide = 1'b0; load_valid = 1'b0; rot_en = 1'b0;
    load_data = '0;
    lv4 = 1'b0; re4 = 1'b0; ld4 = '0; lv25 = 1'b0; re25 = 1'b0; ld25 = '0;
    step(); step();
    check_eq("rst_empty", {31'd0, empty}, 32'd1);
    check_eq("rst_full", {31'd0, full}, 32'd0);
    check_eq("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check_eq("rst_out", out_data, 32'd0);
    check_eq("rst_fill", {28'd0, fill_count}, 32'd0);
    check_eq("rst_head_idx", {28'd0, head_idx}, 32'd0);
    check_eq("rst_pass", {31'd0, pass_done}, 32'd0);
    rst = 1'b0;
    step();

    // 1. fill to full
    load9(1, 1'b0);
    check_eq("t1_fill1", {28'd0, fill_count}, 32'd1);
    check_eq("t1_out_partial", out_data, 32'd0);
    for (int n = 2; n <= 9; n++) load9(n, 1'b0);
    check_eq("t1_full", {31'd0, full}, 32'd1);
    check_eq("t1_load_ready", {31'd0, load_ready}, 32'd0);
    check_eq("t1_head", out_data, lanes(1));
    check_eq("t1_fill9", {28'd0, fill_count}, 32'd9);

    // 2. one full rotation pass
    for (int r = 1; r <= 9; r++) begin
      rot9();
      check_eq($sformatf("t2_head_r%0d", r), out_data, lanes((r % 9) + 1));
      check_eq($sformatf("t2_idx_r%0d", r), {28'd0, head_idx}, 32'(r % 9));
      check_eq($sformatf("t2_pass_r%0d", r), {31'd0, pass_done}, (r == 9) ? 32'd1 : 32'd0);
    end
    step();
    check_eq("t2_pass_drop", {31'd0, pass_done}, 32'd0);

    // 4. slide load with same-cycle rotate
    cfg_slide = 1'b1;
    #1;
    check_eq("t4_ready_slide", {31'd0, load_ready}, 32'd1);
    load9(10, 1'b1);
    check_eq("t4_head", out_data, lanes(2));
    check_eq("t4_fill", {28'd0, fill_count}, 32'd9);
    check_eq("t4_idx", {28'd0, head_idx}, 32'd0);
    cfg_slide = 1'b0;
    for (int r = 1; r <= 8; r++) rot9();
    check_eq("t4_tail", out_data, lanes(10));
    check_eq("t4_idx8", {28'd0, head_idx}, 32'd8);
    rot9();
    check_eq("t4_wrap_head", out_data, lanes(2));
    check_eq("t4_wrap_pass", {31'd0, pass_done}, 32'd1);

    // 5. clear mid-rotation overrides a ready load
    for (int r = 1; r <= 4; r++) rot9();
    check_eq("t5_idx4", {28'd0, head_idx}, 32'd4);
    cfg_slide = 1'b1; clear = 1'b1; load_valid = 1'b1; load_data = lanes(20);
    #1;
    check_eq("t5_ready_during_clear", {31'd0, load_ready}, 32'd1);
    step();
    clear = 1'b0; load_valid = 1'b0; cfg_slide = 1'b0;
    check_eq("t5_empty", {31'd0, empty}, 32'd1);
    check_eq("t5_out", out_data, 32'd0);
    check_eq("t5_idx", {28'd0, head_idx}, 32'd0);
    check_eq("t5_fill", {28'd0, fill_count}, 32'd0);

    // 3. rotate ignored while partial; load refused while full
    for (int n = 1; n <= 5; n++) load9(n, 1'b0);
    check_eq("t3_fill5", {28'd0, fill_count}, 32'd5);
    rot9();
    check_eq("t3_fill_after_rot", {28'd0, fill_count}, 32'd5);
    check_eq("t3_idx_after_rot", {28'd0, head_idx}, 32'd0);
    for (int n = 6; n <= 9; n++) load9(n, 1'b0);
    check_eq("t3_head_after_fill", out_data, lanes(1));
    load_valid = 1'b1; load_data = lanes(10);
    #1;
    check_eq("t3_ready_full", {31'd0, load_ready}, 32'd0);
    step();
    load_valid = 1'b0;
    check_eq("t3_fill_kept", {28'd0, fill_count}, 32'd9);
    check_eq("t3_head_kept", out_data, lanes(1));

    // 5b. asynchronous reset mid-cycle
    rot9(); rot9();
    check_eq("t5b_pre_head", out_data, lanes(3));
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5b_out", out_data, 32'd0);
    check_eq("t5b_fill", {28'd0, fill_count}, 32'd0);
    check_eq("t5b_idx", {28'd0, head_idx}, 32'd0);
    check_eq("t5b_empty", {31'd0, empty}, 32'd1);
    step();
    rst = 1'b0;
    step();

    // 6. depth sweep with per-lane ramps
    sweep(0, 4);
    sweep(1, 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
